// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory write checker:
// checker state encoding and failure-code values.
package mem_check_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } chk_state_e;

  localparam logic [1:0] FC_NONE        = 2'd0;
  localparam logic [1:0] FC_ILLEGAL_ADR = 2'd1;
  localparam logic [1:0] FC_MISMATCH    = 2'd2;
  localparam logic [1:0] FC_TIMEOUT     = 2'd3;

endpackage

// File: rtl/mem_write_checker_if.sv
// Data-memory write port as seen by the core (master)
// and by the checker monitoring it (slave).
interface mem_write_if #(
    parameter int WIDTH = 32
);

    logic             MemWrite;
    logic [WIDTH-1:0] Adr;
    logic [WIDTH-1:0] WriteData;

    modport master (
        output MemWrite,
        output Adr,
        output WriteData
    );

    modport slave (
        input MemWrite,
        input Adr,
        input WriteData
    );

endinterface

// File: rtl/addr_set_match.sv
// Combinational membership test of an address against
// a packed list of N addresses (entry 0 in the LSBs).
module addr_set_match #(
    parameter int               WIDTH = 32,
    parameter int               N     = 1,
    parameter logic [N*WIDTH-1:0] LIST  = '0
) (
    input  logic [WIDTH-1:0] adr,
    output logic             hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (adr == LIST[i*WIDTH +: WIDTH]) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_write_checker.sv
// Monitors the data-memory write port and latches a sticky
// pass/fail/timeout verdict with failure capture.
module mem_write_checker
    import mem_check_pkg::*;
#(
    parameter int                         WIDTH          = 32,
    parameter int                         MODE           = 0,
    parameter int                         N_ALLOWED      = 1,
    parameter logic [N_ALLOWED*WIDTH-1:0] ALLOWED_ADDRS  = 32'd96,
    parameter logic [WIDTH-1:0]           PASS_ADDR      = 100,
    parameter logic [WIDTH-1:0]           PASS_DATA      = 7,
    parameter int                         EXP_DEPTH      = 4,
    parameter logic [EXP_DEPTH*WIDTH-1:0] EXP_ADDRS      = '0,
    parameter logic [EXP_DEPTH*WIDTH-1:0] EXP_DATA       = '0,
    parameter int                         TIMEOUT_CYCLES = 10000,
    parameter int                         CNT_W          = 16,
    localparam int IDX_W = (EXP_DEPTH > 1) ? $clog2(EXP_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    mem_write_if.slave       bus,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [1:0]       fail_code,
    output logic [WIDTH-1:0] fail_adr,
    output logic [WIDTH-1:0] fail_data,
    output logic [CNT_W-1:0] write_count,
    output logic [IDX_W-1:0] seq_idx
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(EXP_DEPTH - 1);

    // A limit the cycle counter can never reach would otherwise alias
    // after truncation, so it simply disables the timeout.
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0) &&
                           (((TIMEOUT_CYCLES - 1) >> CNT_W) == 0);
    localparam logic [CNT_W-1:0] TO_LAST =
        TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    chk_state_e       state;
    logic [CNT_W-1:0] cycCnt;
    logic             allowedHit;
    logic [WIDTH-1:0] expAdr;
    logic [WIDTH-1:0] expData;
    logic             accept;
    logic             toPass;
    logic [1:0]       badCode;
    logic             toTimeout;

    addr_set_match #(
        .WIDTH (WIDTH),
        .N     (N_ALLOWED),
        .LIST  (ALLOWED_ADDRS)
    ) uAllowed (
        .adr (bus.Adr),
        .hit (allowedHit)
    );

    assign expAdr    = EXP_ADDRS[int'(seq_idx)*WIDTH +: WIDTH];
    assign expData   = EXP_DATA[int'(seq_idx)*WIDTH +: WIDTH];
    assign toTimeout = TO_EN && (cycCnt == TO_LAST);

    // Classify the write currently on the bus.
    always_comb begin
        accept  = 1'b0;
        toPass  = 1'b0;
        badCode = FC_NONE;
        if (MODE == 0) begin
            if (bus.Adr == PASS_ADDR) begin
                if (bus.WriteData == PASS_DATA) begin
                    accept = 1'b1;
                    toPass = 1'b1;
                end else begin
                    badCode = FC_MISMATCH;
                end
            end else if (allowedHit) begin
                accept = 1'b1;
            end else begin
                badCode = FC_ILLEGAL_ADR;
            end
        end else begin
            if (bus.Adr == expAdr) begin
                if (bus.WriteData == expData) begin
                    accept = 1'b1;
                    toPass = (seq_idx == LAST_IDX);
                end else begin
                    badCode = FC_MISMATCH;
                end
            end else begin
                badCode = FC_ILLEGAL_ADR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            cycCnt      <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            fail_code   <= FC_NONE;
            fail_adr    <= '0;
            fail_data   <= '0;
            write_count <= '0;
            seq_idx     <= '0;
        end else if (state == RUN) begin
            if (cycCnt != CNT_MAX) begin
                cycCnt <= cycCnt + 1'b1;
            end
            // A sampled write always wins over a same-cycle timeout.
            if (bus.MemWrite) begin
                if (accept) begin
                    if (write_count != CNT_MAX) begin
                        write_count <= write_count + 1'b1;
                    end
                    if (toPass) begin
                        state <= PASS;
                        done  <= 1'b1;
                        pass  <= 1'b1;
                    end else if (MODE != 0) begin
                        seq_idx <= seq_idx + 1'b1;
                    end
                end else begin
                    state     <= FAIL;
                    done      <= 1'b1;
                    fail      <= 1'b1;
                    fail_code <= badCode;
                    fail_adr  <= bus.Adr;
                    fail_data <= bus.WriteData;
                end
            end else if (toTimeout) begin
                state     <= TIMEOUT;
                done      <= 1'b1;
                timeout   <= 1'b1;
                fail_code <= FC_TIMEOUT;
            end
        end
    end

endmodule
